// File: rtl/outpass4_stream_buf.sv
// Fabric-to-pad 4-bit output pass with combinational, registered and FIFO modes.
// The mode is taken from a registered copy of ConfigBits; any change flushes all state.
module outpass4_stream_buf #(
  parameter int DEPTH        = 4,
  parameter int NoConfigBits = 2
) (
  input  logic                       UserCLK,
  input  logic                       Reset,
  input  logic [3:0]                 I,
  input  logic                       I_valid,
  output logic                       I_ready,
  output logic [3:0]                 O,
  output logic                       O_valid,
  input  logic                       O_ready,
  output logic [$clog2(DEPTH+1)-1:0] Level,
  input  logic [NoConfigBits-1:0]    ConfigBits
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam logic [LVL_W-1:0] FULL_CNT = LVL_W'(DEPTH);

  localparam logic [1:0] MODE_COMB = 2'b00;
  localparam logic [1:0] MODE_FIFO = 2'b10;

  logic [NoConfigBits-1:0] r_mode_q;
  logic [PTR_W-1:0]        r_rd_ptr;
  logic [PTR_W-1:0]        r_wr_ptr;
  logic [LVL_W-1:0]        r_count;
  logic [3:0]              r_mem [DEPTH];
  logic [3:0]              r_q;
  logic                    r_qv;

  logic [1:0] w_mode;
  logic       w_mode_chg;
  logic       w_is_fifo;
  logic       w_is_reg;
  logic       w_fifo_ready;
  logic       w_fifo_valid;
  logic       w_push;
  logic       w_pop;

  // Modes 01 and 11 share the registered path, so bit 0 alone selects it.
  assign w_mode       = r_mode_q[1:0];
  assign w_mode_chg   = (ConfigBits != r_mode_q);
  assign w_is_fifo    = (w_mode == MODE_FIFO);
  assign w_is_reg     = w_mode[0];
  assign w_fifo_ready = (r_count != FULL_CNT);
  assign w_fifo_valid = (r_count != '0);
  assign w_push       = w_is_fifo & I_valid & w_fifo_ready;
  assign w_pop        = w_is_fifo & w_fifo_valid & O_ready;

  always_comb begin
    I_ready = 1'b1;
    O       = 4'b0;
    O_valid = 1'b0;
    Level   = '0;
    if (w_mode == MODE_COMB) begin
      O       = I;
      O_valid = I_valid;
      I_ready = O_ready;
    end else if (w_is_fifo) begin
      I_ready = w_fifo_ready;
      O_valid = w_fifo_valid;
      O       = w_fifo_valid ? r_mem[r_rd_ptr] : 4'b0;
      Level   = r_count;
    end else begin
      O       = r_q;
      O_valid = r_qv;
    end
  end

  // Control and registered-path state; reset and mode change both flush.
  always_ff @(posedge UserCLK) begin
    if (Reset) begin
      r_mode_q <= ConfigBits;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_q      <= 4'b0;
      r_qv     <= 1'b0;
    end else begin
      r_mode_q <= ConfigBits;
      if (w_mode_chg) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
        r_q      <= 4'b0;
        r_qv     <= 1'b0;
      end else begin
        if (w_is_reg) begin
          r_q  <= I;
          r_qv <= I_valid;
        end
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        if (w_push && !w_pop)      r_count <= r_count + LVL_W'(1);
        else if (!w_push && w_pop) r_count <= r_count - LVL_W'(1);
      end
    end
  end

  // Storage needs no reset: an entry is only visible once count covers it.
  always_ff @(posedge UserCLK) begin
    if (w_push) r_mem[r_wr_ptr] <= I;
  end

endmodule

// File: tb/tb_outpass4_stream_buf.sv
// Bench for outpass4_stream_buf: directed scenarios plus randomized traffic
// compared every cycle against a queue-based behavioural model.
module tb_outpass4_stream_buf;

  localparam int DEPTH = 4;

  logic       UserCLK = 1'b0;
  logic       Reset;
  logic [3:0] I;
  logic       I_valid;
  logic       I_ready;
  logic [3:0] O;
  logic       O_valid;
  logic       O_ready;
  logic [2:0] Level;
  logic [1:0] ConfigBits;

  int tests = 0;
  int fails = 0;

  logic [1:0] m_mode;
  logic [3:0] m_fifo [$];
  logic [3:0] m_q;
  logic       m_qv;

  logic [3:0] e_o;
  logic       e_ov;
  logic       e_ir;
  logic [2:0] e_lvl;

  logic [3:0] s5_exp [6] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h9, 4'h9};

  always #5 UserCLK = ~UserCLK;

  outpass4_stream_buf #(.DEPTH(DEPTH), .NoConfigBits(2)) dut (
    .UserCLK   (UserCLK),
    .Reset     (Reset),
    .I         (I),
    .I_valid   (I_valid),
    .I_ready   (I_ready),
    .O         (O),
    .O_valid   (O_valid),
    .O_ready   (O_ready),
    .Level     (Level),
    .ConfigBits(ConfigBits)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare all outputs against the model at the falling edge.
  task automatic look(input string tag);
    @(negedge UserCLK);
    e_o = 4'b0; e_ov = 1'b0; e_ir = 1'b1; e_lvl = 3'd0;
    if (m_mode == 2'b00) begin
      e_o = I; e_ov = I_valid; e_ir = O_ready;
    end else if (m_mode == 2'b10) begin
      e_ov  = (m_fifo.size() != 0);
      e_o   = e_ov ? m_fifo[0] : 4'b0;
      e_ir  = (m_fifo.size() < DEPTH);
      e_lvl = 3'(m_fifo.size());
    end else begin
      e_o = m_q; e_ov = m_qv;
    end
    chk({tag, ".O"},       {4'b0, O},       {4'b0, e_o});
    chk({tag, ".O_valid"}, {7'b0, O_valid}, {7'b0, e_ov});
    chk({tag, ".I_ready"}, {7'b0, I_ready}, {7'b0, e_ir});
    chk({tag, ".Level"},   {5'b0, Level},   {5'b0, e_lvl});
  endtask

  // Advance the model across one rising edge using the driven inputs.
  task automatic tick();
    @(posedge UserCLK);
    if (Reset) begin
      m_fifo.delete(); m_q = 4'b0; m_qv = 1'b0; m_mode = ConfigBits;
    end else if (ConfigBits != m_mode) begin
      m_fifo.delete(); m_q = 4'b0; m_qv = 1'b0; m_mode = ConfigBits;
    end else if (m_mode == 2'b10) begin
      bit do_pop  = (m_fifo.size() != 0) && O_ready;
      bit do_push = I_valid && (m_fifo.size() < DEPTH);
      if (do_pop)  void'(m_fifo.pop_front());
      if (do_push) m_fifo.push_back(I);
    end else if (m_mode[0]) begin
      m_q = I; m_qv = I_valid;
    end
    #1;
  endtask

  initial begin
    Reset = 1'b1; ConfigBits = 2'b10; I = 4'h0; I_valid = 1'b0; O_ready = 1'b0;
    tick(); tick();
    look("rst");
    chk("rst.O_valid0", {7'b0, O_valid}, 8'h0);
    chk("rst.Level0",   {5'b0, Level},   8'h0);
    chk("rst.O0",       {4'b0, O},       8'h0);
    tick();
    Reset = 1'b0;

    // Fill the FIFO with backpressure held.
    for (int k = 1; k <= 4; k++) begin
      I = 4'(k); I_valid = 1'b1;
      look("s4push"); tick();
    end
    I = 4'h5;
    look("s4full");
    chk("s4.Level4",   {5'b0, Level},   8'h4);
    chk("s4.I_ready0", {7'b0, I_ready}, 8'h0);
    chk("s4.O1",       {4'b0, O},       8'h1);
    tick();
    I_valid = 1'b0;
    look("s4hold");
    chk("s4.no5th", {5'b0, Level}, 8'h4);
    chk("s4.Ohold", {4'b0, O},     8'h1);
    tick();

    // Drain while refilling with 9s; pointers wrap.
    O_ready = 1'b1; I = 4'h9; I_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      look("s5");
      chk("s5.order", {4'b0, O}, {4'b0, s5_exp[k]});
      tick();
    end

    // Reset while holding three words.
    O_ready = 1'b0; Reset = 1'b1;
    look("s1pre");
    chk("s1.Level3", {5'b0, Level}, 8'h3);
    tick();
    Reset = 1'b0; I_valid = 1'b0;
    look("s1post");
    chk("s1.O_valid0", {7'b0, O_valid}, 8'h0);
    chk("s1.Level0",   {5'b0, Level},   8'h0);
    chk("s1.I_ready1", {7'b0, I_ready}, 8'h1);
    chk("s1.O0",       {4'b0, O},       8'h0);
    tick();

    // Combinational mode.
    ConfigBits = 2'b00;
    look("s2chg"); tick();
    I = 4'hA; I_valid = 1'b1; O_ready = 1'b0;
    look("s2");
    chk("s2.OA",       {4'b0, O},       8'hA);
    chk("s2.O_valid1", {7'b0, O_valid}, 8'h1);
    chk("s2.I_ready0", {7'b0, I_ready}, 8'h0);
    O_ready = 1'b1;
    #1;
    chk("s2.I_ready1", {7'b0, I_ready}, 8'h1);
    tick();

    // FIFO with two words, then switch to registered mode.
    ConfigBits = 2'b10; I_valid = 1'b0; O_ready = 1'b0;
    look("s6chg0"); tick();
    I = 4'h6; I_valid = 1'b1;
    look("s6p0"); tick();
    I = 4'h7;
    look("s6p1"); tick();
    I_valid = 1'b0; ConfigBits = 2'b01;
    look("s6chg");
    chk("s6.Level2", {5'b0, Level}, 8'h2);
    tick();
    I = 4'h5; I_valid = 1'b1;
    look("s6a");
    chk("s6.flushed", {5'b0, Level},   8'h0);
    chk("s6.Qv0",     {7'b0, O_valid}, 8'h0);
    tick();
    I = 4'h3;
    look("s6b");
    chk("s6.O5",   {4'b0, O},       8'h5);
    chk("s6.Ir1a", {7'b0, I_ready}, 8'h1);
    tick();
    I_valid = 1'b0;
    look("s6c");
    chk("s6.O3",   {4'b0, O},       8'h3);
    chk("s6.Ir1b", {7'b0, I_ready}, 8'h1);
    tick();

    // Reserved mode 11 behaves as registered.
    ConfigBits = 2'b11;
    look("m11chg"); tick();
    I = 4'hC; I_valid = 1'b1;
    look("m11a"); tick();
    I_valid = 1'b0;
    look("m11b");
    chk("m11.OC", {4'b0, O}, 8'hC);
    tick();

    // Randomized traffic with occasional resets and mode changes.
    ConfigBits = 2'b10;
    for (int n = 0; n < 600; n++) begin
      I       = 4'($urandom);
      I_valid = ($urandom_range(0, 3) != 0);
      O_ready = ((n / 50) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      Reset   = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 39) == 0) begin
        int r = $urandom_range(0, 5);
        ConfigBits = (r > 3) ? 2'b10 : 2'(r);
      end
      look("rnd");
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
